// File: rtl/tm1638_frame_sequencer.sv
// TM1638 frame-level write sequencer: snapshots display inputs and streams the
// mode / address+16 data / display-control byte sequence to a byte shifter.
module tm1638_frame_sequencer #(
  parameter int unsigned RefreshCycles = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] digits_i,
  input  logic [7:0]  leds_i,
  input  logic [2:0]  brightness_i,
  input  logic        display_on_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_valid_o,
  output logic        tx_end_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StMode,
    StAddr,
    StData,
    StCtrl,
    StDone
  } state_e;

  localparam logic [7:0] CmdMode = 8'h40;
  localparam logic [7:0] CmdAddr = 8'hC0;
  localparam logic [7:0] CmdOff  = 8'h80;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [31:0] refresh_q, refresh_d;
  logic [31:0] digits_q;
  logic [7:0]  leds_q;
  logic [2:0]  bright_q;
  logic        on_q;
  logic        snap;
  logic        xfer;
  logic        refresh_fire;
  logic [2:0]  digit_sel;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'h3F;
      4'h1:    code = 8'h06;
      4'h2:    code = 8'h5B;
      4'h3:    code = 8'h4F;
      4'h4:    code = 8'h66;
      4'h5:    code = 8'h6D;
      4'h6:    code = 8'h7D;
      4'h7:    code = 8'h07;
      4'h8:    code = 8'h7F;
      4'h9:    code = 8'h6F;
      4'hA:    code = 8'h77;
      4'hB:    code = 8'h7C;
      4'hC:    code = 8'h39;
      4'hD:    code = 8'h5E;
      4'hE:    code = 8'h79;
      default: code = 8'h00;  // F blanks the digit
    endcase
    return code;
  endfunction

  assign xfer         = tx_valid_o & tx_ready_i;
  assign refresh_fire = (RefreshCycles != 0) && (refresh_q == RefreshCycles - 1);
  assign digit_sel    = idx_q[3:1];

  // Next-state, pending flag, refresh timer and snapshot enable.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    refresh_d = refresh_q;
    snap      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i || refresh_fire) begin
          snap      = 1'b1;
          state_d   = StMode;
          refresh_d = '0;
        end else if (RefreshCycles != 0) begin
          refresh_d = refresh_q + 32'd1;
        end
      end
      StMode: begin
        if (xfer) state_d = StAddr;
      end
      StAddr: begin
        if (xfer) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (xfer) begin
          if (idx_q == 4'd15) state_d = StCtrl;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      StCtrl: begin
        if (xfer) state_d = StDone;
      end
      StDone: begin
        // A start arriving in this very cycle is treated as pending.
        if (pending_q || start_i) begin
          snap      = 1'b1;
          state_d   = StMode;
          pending_d = 1'b0;
        end else begin
          state_d   = StIdle;
          refresh_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (busy_o && start_i) pending_d = 1'b1;
  end

  // Byte presented to the shifter is a pure function of state and snapshot.
  always_comb begin
    tx_byte_o  = 8'h00;
    tx_valid_o = 1'b0;
    tx_end_o   = 1'b0;
    done_o     = 1'b0;

    unique case (state_q)
      StMode: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = CmdMode;
        tx_end_o   = 1'b1;
      end
      StAddr: begin
        tx_valid_o = 1'b1;
        tx_byte_o  = CmdAddr;
      end
      StData: begin
        tx_valid_o = 1'b1;
        tx_end_o   = (idx_q == 4'd15);
        if (idx_q[0]) tx_byte_o = {7'b0, leds_q[digit_sel]};
        else          tx_byte_o = seg_encode(digits_q[{digit_sel, 2'b00} +: 4]);
      end
      StCtrl: begin
        tx_valid_o = 1'b1;
        tx_end_o   = 1'b1;
        tx_byte_o  = on_q ? {5'b10001, bright_q} : CmdOff;
      end
      StDone: done_o = 1'b1;
      default: ;
    endcase

    busy_o = tx_valid_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pending_q <= 1'b0;
      refresh_q <= '0;
      digits_q  <= '0;
      leds_q    <= '0;
      bright_q  <= '0;
      on_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      refresh_q <= refresh_d;
      if (snap) begin
        digits_q <= digits_i;
        leds_q   <= leds_i;
        bright_q <= brightness_i;
        on_q     <= display_on_i;
      end
    end
  end

endmodule

// File: tb/tb_tm1638_frame_sequencer.sv
// Scoreboard bench for tm1638_frame_sequencer: expected byte streams come from a
// frame model; a negedge monitor pops and compares on every accepted byte.
module tb_tm1638_frame_sequencer;

  localparam int unsigned RC = 10;

  logic        clk = 1'b0;
  logic        rst, start, display_on, tx_ready;
  logic [31:0] digits;
  logic [7:0]  leds;
  logic [2:0]  br;
  logic [7:0]  tx_byte;
  logic        tx_valid, tx_end, busy, done;

  logic        r_start, r_ready;
  logic [7:0]  r_tx_byte;
  logic        r_tx_valid, r_tx_end, r_busy, r_done;

  always #5 clk = ~clk;

  tm1638_frame_sequencer #(.RefreshCycles(0)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .digits_i(digits), .leds_i(leds),
    .brightness_i(br), .display_on_i(display_on), .tx_byte_o(tx_byte),
    .tx_valid_o(tx_valid), .tx_end_o(tx_end), .tx_ready_i(tx_ready),
    .busy_o(busy), .done_o(done)
  );

  tm1638_frame_sequencer #(.RefreshCycles(RC)) dut_r (
    .clk_i(clk), .rst_i(rst), .start_i(r_start), .digits_i(digits), .leds_i(leds),
    .brightness_i(br), .display_on_i(display_on), .tx_byte_o(r_tx_byte),
    .tx_valid_o(r_tx_valid), .tx_end_o(r_tx_end), .tx_ready_i(r_ready),
    .busy_o(r_busy), .done_o(r_done)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_exp = 0;
  int last_xfer_cyc = -10;
  bit rand_ready = 0;
  logic [9:0] exp_q[$];  // {last_of_frame, tx_end, tx_byte}

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference frame: 19 bytes computed straight from the display contents.
  task automatic push_frame(input logic [31:0] d, input logic [7:0] l, input logic [2:0] b,
                            input logic on);
    logic [7:0] v;
    exp_q.push_back({2'b01, 8'h40});
    exp_q.push_back({2'b00, 8'hC0});
    for (int j = 0; j < 16; j++) begin
      int i = j / 2;
      if (j % 2 == 0) v = seg_tab[d[4*i +: 4]];
      else            v = l[i] ? 8'd1 : 8'd0;
      exp_q.push_back({1'b0, (j == 15), v});
    end
    v = on ? 8'(8'h88 + 8'(b)) : 8'h80;
    exp_q.push_back({2'b11, v});
    done_exp++;
  endtask

  task automatic randomize_inputs();
    digits     = $urandom;
    leds       = 8'($urandom);
    br         = 3'($urandom);
    display_on = 1'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_frame();
    push_frame(digits, leds, br, display_on);
    pulse_start();
    @(negedge clk);
    check("first_byte", {tx_valid, busy, tx_byte}, {2'b11, 8'h40});
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done, 1'b1);
  endtask

  task automatic run_frame(input bit mutate);
    send_frame();
    if (mutate) begin
      repeat (3) @(posedge clk);
      #1 randomize_inputs();
    end
    wait_done(400);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2 tx_ready = rand_ready ? 1'($urandom) : 1'b1;
    end
  end

  // Monitor: compares every accepted byte, checks holds under stall and done timing.
  initial begin
    bit prev_stall = 0;
    logic [8:0] prev_out = '0;
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (prev_stall && tx_valid) check("hold_while_stalled", {tx_end, tx_byte}, prev_out);
      prev_stall = tx_valid && !tx_ready;
      prev_out   = {tx_end, tx_byte};
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %0h expected no transfer (cycle %0d)",
                   {tx_end, tx_byte}, cyc);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", {tx_end, tx_byte}, e[8:0]);
          if (e[9]) last_xfer_cyc = cyc;
        end
      end
      if (done) begin
        done_seen++;
        check("done_after_ctrl", cyc, last_xfer_cyc + 1);
        check("done_quiet", {busy, tx_valid}, 2'b00);
      end
    end
  end

  initial begin
    int n;
    int bad;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1; r_start = 1'b0; r_ready = 1'b1;
    randomize_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {tx_valid, tx_end, busy, done, tx_byte}, '0);
    check("reset_outputs_refresh", {r_tx_valid, r_busy, r_done}, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed frame.
    digits = 32'hFFFF_F123; leds = 8'h05; br = 3'd7; display_on = 1'b1;
    run_frame(1'b0);

    // Random frames with random back-pressure; some mutate inputs mid-frame.
    rand_ready = 1;
    for (int k = 0; k < 6; k++) begin
      randomize_inputs();
      run_frame(k[0]);
    end

    // Three starts while busy merge into one extra frame with a fresh snapshot.
    randomize_inputs();
    send_frame();
    @(posedge clk); #1 randomize_inputs();
    push_frame(digits, leds, br, display_on);
    repeat (3) pulse_start();
    wait_done(400);
    @(negedge clk);
    check("pending_restart", {tx_valid, busy, tx_byte}, {2'b11, 8'h40});
    wait_done(400);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_valid) bad++;
    end
    check("no_extra_frame", bad, 0);

    // Start coinciding with the done cycle.
    send_frame();
    wait_done(400);
    #1 start = 1'b1;
    push_frame(digits, leds, br, display_on);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("start_in_done", {tx_valid, busy, tx_byte}, {2'b11, 8'h40});
    wait_done(400);

    // Display-control byte with display off / on.
    br = 3'd5; display_on = 1'b0;
    run_frame(1'b0);
    display_on = 1'b1;
    run_frame(1'b0);

    // Reset mid-frame with a pending request outstanding.
    send_frame();
    pulse_start();
    n = 0; bad = 0;
    while (n < 7 && bad < 400) begin
      @(negedge clk);
      if (tx_valid && tx_ready) n++;
      bad++;
    end
    check("reached_byte7", n, 7);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    done_exp--;
    @(negedge clk);
    check("rst_midframe_outputs", {tx_valid, tx_end, busy, done, tx_byte}, '0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_valid || done) bad++;
    end
    check("pending_dropped_by_rst", bad, 0);

    // Auto-refresh instance: RC idle cycles after the done cycle, then a new frame.
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!r_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("refresh_done_seen", r_done, 1'b1);
      n = 0;
      @(negedge clk);
      n++;
      while (!r_tx_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("refresh_gap", n, RC + 1);
      check("refresh_first_byte", r_tx_byte, 8'h40);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_seen, done_exp);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
